// File: rtl/s3g_packet_rx.sv
// S3G frame receiver (D5 / len / payload / CRC-8 Maxim); optional inter-byte timeout via S3G_RX_TIMEOUT_EN.
// Latency: done/error pulse one clock after the closing byte; no backpressure, a byte is taken whenever rx_done=1.
module s3g_packet_rx #(
  parameter int MAX_PAYLOAD    = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       packet_done,
  output logic       packet_error,
  output logic [7:0] payload_len,
  output logic       buffer_valid,
  output logic [7:0] buf0,
  output logic [7:0] buf1,
  output logic [7:0] buf2,
  output logic [7:0] buf3,
  output logic [7:0] buf4,
  output logic [7:0] buf5,
  output logic [7:0] buf6,
  output logic [7:0] buf7,
  output logic [7:0] buf8,
  output logic [7:0] buf9,
  output logic [7:0] buf10,
  output logic [7:0] buf11,
  output logic [7:0] buf12,
  output logic [7:0] buf13,
  output logic [7:0] buf14,
  output logic [7:0] buf15,
  input  logic [7:0] buffer_addr,
  output logic [7:0] buffer_data
);

  localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
  localparam logic [7:0] SYNC    = 8'hD5;

  typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CRC} state_t;

  state_t     state_q, state_d;
  logic [7:0] crc_q;
  logic [7:0] idx_q;
  logic [7:0] buf_q [16];
  logic [7:0] mem [MAX_PAYLOAD];
  logic       done_d, err_d;
  logic       to_hit;

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 8'h8C) : (x >> 1);
    return x;
  endfunction

`ifdef S3G_RX_TIMEOUT_EN
  logic [31:0] to_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               to_cnt <= '0;
    else if (rx_done || state_q == ST_IDLE) to_cnt <= '0;
    else                                   to_cnt <= to_cnt + 32'd1;
  end
  // A byte arriving on the expiry cycle wins over the timeout.
  assign to_hit = (state_q != ST_IDLE) && !rx_done && (to_cnt == 32'(TIMEOUT_CYCLES));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (to_hit) begin
      state_d = ST_IDLE;
    end else if (rx_done) begin
      case (state_q)
        ST_IDLE:    if (rx_data == SYNC) state_d = ST_LEN;
        ST_LEN: begin
          if (rx_data > MAX_LEN)     state_d = ST_IDLE;
          else if (rx_data == 8'd0)  state_d = ST_CRC;
          else                       state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: if (idx_q + 8'd1 == payload_len) state_d = ST_CRC;
        ST_CRC:     state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done_d = rx_done && (state_q == ST_CRC) && (rx_data == crc_q);
    err_d  = to_hit
           || (rx_done && (state_q == ST_LEN) && (rx_data > MAX_LEN))
           || (rx_done && (state_q == ST_CRC) && (rx_data != crc_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      packet_done  <= 1'b0;
      packet_error <= 1'b0;
      payload_len  <= '0;
      buffer_valid <= 1'b0;
      crc_q        <= '0;
      idx_q        <= '0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      packet_done  <= done_d;
      packet_error <= err_d;
      if (rx_done) begin
        case (state_q)
          ST_IDLE: if (rx_data == SYNC) begin
            buffer_valid <= 1'b0;
            crc_q        <= '0;
            idx_q        <= '0;
          end
          ST_LEN: payload_len <= rx_data;
          ST_PAYLOAD: begin
            if (idx_q < 8'd16) buf_q[idx_q[3:0]] <= rx_data;
            crc_q <= crc8_upd(crc_q, rx_data);
            idx_q <= idx_q + 8'd1;
          end
          ST_CRC: if (done_d) buffer_valid <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Payload memory is deliberately not reset; reads are masked by buffer_valid.
  always_ff @(posedge clk) begin
    if (rx_done && state_q == ST_PAYLOAD) mem[idx_q[AW-1:0]] <= rx_data;
  end

  assign buffer_data = (buffer_valid && buffer_addr < MAX_LEN) ? mem[buffer_addr[AW-1:0]] : 8'h00;

  assign buf0  = buf_q[0];
  assign buf1  = buf_q[1];
  assign buf2  = buf_q[2];
  assign buf3  = buf_q[3];
  assign buf4  = buf_q[4];
  assign buf5  = buf_q[5];
  assign buf6  = buf_q[6];
  assign buf7  = buf_q[7];
  assign buf8  = buf_q[8];
  assign buf9  = buf_q[9];
  assign buf10 = buf_q[10];
  assign buf11 = buf_q[11];
  assign buf12 = buf_q[12];
  assign buf13 = buf_q[13];
  assign buf14 = buf_q[14];
  assign buf15 = buf_q[15];

endmodule

// File: tb/tb_s3g_packet_rx.sv
// Randomized bench for s3g_packet_rx: whole frames are generated and checked against a packet-level model.
module tb_s3g_packet_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       packet_done, packet_error, buffer_valid;
  logic [7:0] payload_len, buffer_addr, buffer_data;
  logic [7:0] bufs [16];

  s3g_packet_rx #(.MAX_PAYLOAD(32), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .packet_done(packet_done), .packet_error(packet_error),
    .payload_len(payload_len), .buffer_valid(buffer_valid),
    .buf0(bufs[0]), .buf1(bufs[1]), .buf2(bufs[2]), .buf3(bufs[3]),
    .buf4(bufs[4]), .buf5(bufs[5]), .buf6(bufs[6]), .buf7(bufs[7]),
    .buf8(bufs[8]), .buf9(bufs[9]), .buf10(bufs[10]), .buf11(bufs[11]),
    .buf12(bufs[12]), .buf13(bufs[13]), .buf14(bufs[14]), .buf15(bufs[15]),
    .buffer_addr(buffer_addr), .buffer_data(buffer_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0;

  always @(negedge clk) begin
    if (packet_done)  done_cnt++;
    if (packet_error) err_cnt++;
  end

  // Expected view of the receiver after each frame.
  logic [7:0] m_len;
  logic       m_valid;
  logic [7:0] m_mem [32];
  bit         m_known [32];
  logic [7:0] m_buf [16];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] q[$]);
    logic [7:0] c;
    c = 8'h00;
    foreach (q[i]) begin
      c = c ^ q[i];
      repeat (8) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
    end
    return c;
  endfunction

  function automatic int pick_gap(input int gap);
    return (gap >= 0) ? gap : int'($urandom_range(0, 5));
  endfunction

  // Entered and left on a falling edge; the byte is accepted on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic model_reset();
    m_len = 8'h00;
    m_valid = 1'b0;
    for (int i = 0; i < 16; i++) m_buf[i] = 8'h00;
    for (int i = 0; i < 32; i++) m_known[i] = 1'b0;
  endtask

  task automatic check_state();
    logic [7:0] e;
    check_eq("payload_len", 32'(payload_len), 32'(m_len));
    check_eq("buffer_valid", 32'(buffer_valid), 32'(m_valid));
    for (int i = 0; i < 16; i++) check_eq($sformatf("buf%0d", i), 32'(bufs[i]), 32'(m_buf[i]));
    for (int a = 0; a < 41; a++) begin
      buffer_addr = (a == 40) ? 8'hFF : 8'(a);
      #1;
      if (!m_valid || a >= 32) e = 8'h00;
      else e = m_mem[a];
      if (!m_valid || a >= 32 || m_known[a])
        check_eq($sformatf("buffer_data[%0d]", buffer_addr), 32'(buffer_data), 32'(e));
    end
    @(negedge clk);
  endtask

  // One frame: optional noise, D5, length, payload, CRC (crc_ov<0 sends the correct CRC).
  task automatic run_packet(input logic [7:0] len, input logic [7:0] pl[$], input int crc_ov,
                            input int noise, input int gap);
    int d0, e0;
    bit good;
    logic [7:0] b, c, cb;
    for (int i = 0; i < noise; i++) begin
      b = 8'($urandom);
      if (b == 8'hD5) b = 8'h00;
      send_byte(b, pick_gap(gap));
    end
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hD5, pick_gap(gap));
    check_eq("valid_after_sync", 32'(buffer_valid), 32'd0);
    m_valid = 1'b0;
    send_byte(len, pick_gap(gap));
    m_len = len;
    good = 1'b0;
    if (len <= 8'd32) begin
      foreach (pl[i]) begin
        send_byte(pl[i], pick_gap(gap));
        m_mem[i] = pl[i];
        m_known[i] = 1'b1;
        if (i < 16) m_buf[i] = pl[i];
      end
      check_eq("valid_before_crc", 32'(buffer_valid), 32'd0);
      c  = ref_crc(pl);
      cb = (crc_ov >= 0) ? 8'(crc_ov) : c;
      send_byte(cb, pick_gap(gap));
      good = (cb == c);
    end
    check_eq("done_pulse", 32'(packet_done), 32'(good));
    check_eq("err_pulse", 32'(packet_error), 32'(!good));
    @(negedge clk);
    check_eq("done_pulse_end", 32'(packet_done), 32'd0);
    check_eq("err_pulse_end", 32'(packet_error), 32'd0);
    check_eq("done_count", 32'(done_cnt - d0), 32'(good));
    check_eq("err_count", 32'(err_cnt - e0), 32'(!good));
    m_valid = good;
    check_state();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] len;
    int d0, e0, kind;

    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    buffer_addr = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_done", 32'(packet_done), 32'd0);
    check_eq("rst_err", 32'(packet_error), 32'd0);
    check_state();
    rst = 1'b0;
    @(negedge clk);

    // Noise then bad CRC
    send_byte(8'h0D, 1);
    q = '{8'h01, 8'h02, 8'h03};
    run_packet(8'd3, q, 'hCC, 0, 1);
    // Good packet with the reference check value
    run_packet(8'd3, q, 'hD8, 0, 1);
    // Leading zero payload byte
    q = '{8'h00, 8'h01, 8'h02};
    run_packet(8'd3, q, 'h78, 0, 0);
    // Oversize length, then normal traffic
    q.delete();
    run_packet(8'h28, q, -1, 0, 0);
    q = '{8'h01, 8'h02, 8'h03};
    run_packet(8'd3, q, 'hD8, 0, 0);
    // Zero length, back-to-back, and wide byte spacing
    q.delete();
    run_packet(8'd0, q, 'h00, 0, 5);
    q = '{8'hD5, 8'hD5};
    run_packet(8'd2, q, -1, 0, 5);
    // Maximum length
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(8'(i * 7 + 1));
    run_packet(8'd32, q, -1, 0, 0);
    run_packet(8'd33, q, -1, 0, 0);

    // Reset in the middle of a frame
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'hD5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h01, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("midrst_done", 32'(packet_done), 32'd0);
    check_eq("midrst_err", 32'(packet_error), 32'd0);
    check_state();
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    q = '{8'h01, 8'h02, 8'h03};
    run_packet(8'd3, q, -1, 0, 1);

    // Randomized frames
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 9));
      q.delete();
      if (kind == 0) begin
        len = 8'($urandom_range(33, 255));
        run_packet(len, q, -1, int'($urandom_range(0, 3)), -1);
      end else begin
        len = 8'($urandom_range(0, 32));
        for (int i = 0; i < int'(len); i++)
          q.push_back(($urandom_range(0, 7) == 0) ? 8'hD5 : 8'($urandom));
        if (kind <= 2)
          run_packet(len, q, int'(ref_crc(q) ^ 8'($urandom_range(1, 255))),
                     int'($urandom_range(0, 3)), -1);
        else
          run_packet(len, q, -1, int'($urandom_range(0, 3)), -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
